// File: rtl/uart_transmitter.sv
// uart_transmitter: buffered UART transmitter, LSB first, optional parity bit. Rev 1.0
`default_nettype none

module uart_transmitter #(
  parameter int DATA_BITS      = 8,
  parameter int STOP_BIT_TICKS = 16,
  parameter int PARITY_EN      = 0,
  parameter int PARITY_ODD     = 0
) (
  input  logic                 Clock,
  input  logic                 ResetN,
  input  logic                 Tick,
  input  logic                 TxStart,
  input  logic [DATA_BITS-1:0] TxDataIn,
  output logic                 TxReady,
  output logic                 TxBusy,
  output logic                 TxDone,
  output logic                 Tx
);

  localparam int TW = (STOP_BIT_TICKS > 16) ? $clog2(STOP_BIT_TICKS) : 4;
  localparam int DW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [TW-1:0] BIT_LAST  = TW'(15);
  localparam logic [TW-1:0] STOP_LAST = TW'(STOP_BIT_TICKS - 1);
  localparam logic [DW-1:0] DATA_LAST = DW'(DATA_BITS - 1);
  localparam logic          USE_PAR   = (PARITY_EN != 0);
  localparam logic          ODD_PAR   = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [TW-1:0]          tick_q, tick_d;
  logic [DW-1:0]          bit_q, bit_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic [DATA_BITS-1:0]   hold_data;
  logic                   hold_valid;
  logic                   parity_q;
  logic                   tx_q, tx_d;
  logic                   load;
  logic                   done;

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      hold_valid <= 1'b0;
      hold_data  <= '0;
    end else if (load) begin
      hold_valid <= 1'b0;
    end else if (TxStart && !hold_valid) begin
      hold_valid <= 1'b1;
      hold_data  <= TxDataIn;
    end
  end

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state_q  <= IDLE;
      tick_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      parity_q <= 1'b0;
      tx_q     <= 1'b1;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      // Parity is latched from the byte as loaded, independent of shifting
      if (load) parity_q <= (^hold_data) ^ ODD_PAR;
    end
  end

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    load    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (hold_valid) begin
          state_d = START;
          shift_d = hold_data;
          tick_d  = '0;
          load    = 1'b1;
        end
      end
      START: begin
        if (Tick) begin
          if (tick_q == BIT_LAST) begin
            state_d = DATA;
            tick_d  = '0;
            bit_d   = '0;
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
      end
      DATA: begin
        if (Tick) begin
          if (tick_q == BIT_LAST) begin
            shift_d = shift_q >> 1;
            tick_d  = '0;
            if (bit_q == DATA_LAST) state_d = USE_PAR ? PARITY : STOP;
            else                    bit_d   = bit_q + DW'(1);
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
      end
      PARITY: begin
        if (Tick) begin
          if (tick_q == BIT_LAST) begin
            state_d = STOP;
            tick_d  = '0;
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
      end
      STOP: begin
        if (Tick) begin
          if (tick_q == STOP_LAST) begin
            done   = 1'b1;
            tick_d = '0;
            // A pending byte starts immediately, with no idle gap
            if (hold_valid) begin
              state_d = START;
              shift_d = hold_data;
              load    = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Line level is derived from the next state so Tx is a clean flop output
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      PARITY:  tx_d = parity_q;
      default: tx_d = 1'b1;
    endcase
  end

  assign TxReady = !hold_valid;
  assign TxBusy  = (state_q != IDLE);
  assign TxDone  = done;
  assign Tx      = tx_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_transmitter.sv
// tb_uart_transmitter: three parity configurations driven in parallel against a frame-level model.
`default_nettype none

module tb_uart_transmitter;

  logic       Clock = 1'b0;
  logic       ResetN = 1'b0;
  logic       Tick = 1'b0;
  logic       TxStart = 1'b0;
  logic [7:0] TxDataIn = 8'h00;
  logic [2:0] rdy, busy, done, tx;

  always #5 Clock = ~Clock;

  uart_transmitter #(.DATA_BITS(8), .STOP_BIT_TICKS(16), .PARITY_EN(0), .PARITY_ODD(0)) u0 (
    .Clock(Clock), .ResetN(ResetN), .Tick(Tick), .TxStart(TxStart), .TxDataIn(TxDataIn),
    .TxReady(rdy[0]), .TxBusy(busy[0]), .TxDone(done[0]), .Tx(tx[0]));
  uart_transmitter #(.DATA_BITS(8), .STOP_BIT_TICKS(16), .PARITY_EN(1), .PARITY_ODD(0)) u1 (
    .Clock(Clock), .ResetN(ResetN), .Tick(Tick), .TxStart(TxStart), .TxDataIn(TxDataIn),
    .TxReady(rdy[1]), .TxBusy(busy[1]), .TxDone(done[1]), .Tx(tx[1]));
  uart_transmitter #(.DATA_BITS(8), .STOP_BIT_TICKS(16), .PARITY_EN(1), .PARITY_ODD(1)) u2 (
    .Clock(Clock), .ResetN(ResetN), .Tick(Tick), .TxStart(TxStart), .TxDataIn(TxDataIn),
    .TxReady(rdy[2]), .TxBusy(busy[2]), .TxDone(done[2]), .Tx(tx[2]));

  // Frame-level model per instance: pending byte, current frame as a bit list, position, ticks
  bit         m_hv[3];
  logic [7:0] m_hd[3];
  bit         m_act[3];
  logic [10:0] m_fr[3];
  int         m_nb[3], m_pos[3], m_tk[3], m_frames[3], dut_done[3];
  int         errors = 0, checks = 0, cyc = 0, tick_mode = 0;

  function automatic logic [10:0] make_frame(int cfg, logic [7:0] b);
    logic [10:0] f;
    f = '1;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i+1] = b[i];
    if (cfg > 0) f[9] = (($countones(b) % 2) == 1) ^ (cfg == 2);
    return f;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset(input int k);
    m_hv[k] = 0; m_hd[k] = 8'h00; m_act[k] = 0; m_pos[k] = 0; m_tk[k] = 0;
  endtask

  task automatic model_load(input int k);
    m_fr[k] = make_frame(k, m_hd[k]);
    m_nb[k] = (k > 0) ? 11 : 10;
    m_pos[k] = 0; m_tk[k] = 0; m_act[k] = 1; m_hv[k] = 0;
  endtask

  task automatic model_edge(input int k);
    bit acc;
    acc = TxStart && !m_hv[k];
    if (m_act[k]) begin
      if (Tick) begin
        m_tk[k]++;
        if (m_tk[k] == 16) begin
          m_tk[k] = 0;
          m_pos[k]++;
          if (m_pos[k] == m_nb[k]) begin
            m_act[k] = 0;
            m_frames[k]++;
            if (m_hv[k]) model_load(k);
          end
        end
      end
    end else if (m_hv[k]) begin
      model_load(k);
    end
    if (acc) begin
      m_hv[k] = 1;
      m_hd[k] = TxDataIn;
    end
  endtask

  task automatic step(input logic rn, input logic st, input logic [7:0] d);
    logic exp_done;
    @(negedge Clock);
    ResetN = rn; TxStart = st; TxDataIn = d;
    case (tick_mode)
      0:       Tick = ((cyc % 24) == 23);
      1:       Tick = ($urandom_range(0, 2) == 0);
      default: Tick = 1'b0;
    endcase
    cyc++;
    #1;
    for (int k = 0; k < 3; k++) begin
      if (!rn) model_reset(k);
      exp_done = m_act[k] && Tick && (m_tk[k] == 15) && (m_pos[k] == m_nb[k] - 1);
      check($sformatf("tx[%0d] cyc%0d", k, cyc), 32'(tx[k]), 32'(m_act[k] ? m_fr[k][m_pos[k]] : 1'b1));
      check($sformatf("busy[%0d] cyc%0d", k, cyc), 32'(busy[k]), 32'(m_act[k]));
      check($sformatf("ready[%0d] cyc%0d", k, cyc), 32'(rdy[k]), 32'(!m_hv[k]));
      check($sformatf("done[%0d] cyc%0d", k, cyc), 32'(done[k]), 32'(exp_done));
      if (done[k]) dut_done[k]++;
    end
    @(posedge Clock);
    if (rn) for (int k = 0; k < 3; k++) model_edge(k);
  endtask

  task automatic run_idle(input int bound);
    int n;
    n = 0;
    while ((m_act[0] || m_act[1] || m_act[2] || m_hv[0] || m_hv[1] || m_hv[2]) && n < bound) begin
      step(1'b1, 1'b0, 8'h00);
      n++;
    end
    check("idle_timeout", 32'(n < bound), 32'd1);
  endtask

  initial begin
    int n;
    for (int k = 0; k < 3; k++) begin
      model_reset(k); m_frames[k] = 0; dut_done[k] = 0; m_nb[k] = 10;
    end
    // Reset state
    repeat (3) step(1'b0, 1'b0, 8'h00);

    // Basic frame A5, then parity reference byte 07
    step(1'b1, 1'b1, 8'hA5);
    run_idle(8000);
    step(1'b1, 1'b1, 8'h07);
    run_idle(8000);

    // Back-to-back: second byte queued during START, third ignored while hold is full
    step(1'b1, 1'b1, 8'h55);
    repeat (30) step(1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b1, 8'hC3);
    repeat (10) step(1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b1, 8'hFF);
    run_idle(20000);

    // Reset pulse in the middle of data bit 3, then a clean frame
    step(1'b1, 1'b1, 8'h96);
    n = 0;
    while (m_pos[0] != 4 && n < 5000) begin
      step(1'b1, 1'b0, 8'h00);
      n++;
    end
    check("reach_bit3", 32'(m_pos[0]), 32'd4);
    repeat (100) step(1'b1, 1'b0, 8'h00);
    repeat (2) step(1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b1, 8'h3C);
    run_idle(8000);

    // Tick stall during START
    step(1'b1, 1'b1, 8'h5A);
    repeat (50) step(1'b1, 1'b0, 8'h00);
    tick_mode = 2;
    repeat (1000) step(1'b1, 1'b0, 8'h00);
    tick_mode = 0;
    run_idle(8000);

    // Randomized traffic with irregular ticks and occasional resets
    tick_mode = 1;
    for (int i = 0; i < 15000; i++)
      step(($urandom_range(0, 3999) != 0), ($urandom_range(0, 63) == 0), 8'($urandom));
    run_idle(8000);

    for (int k = 0; k < 3; k++)
      check($sformatf("done_count[%0d]", k), 32'(dut_done[k]), 32'(m_frames[k]));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
